// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR tap sequencer: feeds one sample*coefficient operation per tap
// to an external MAC and accumulates the returned products into one result per sample.
module fir_mac_sequencer #(
  parameter int          NTAPS   = 16,
  parameter int          AW      = $clog2(NTAPS),
  parameter logic [47:0] ROUND_C = 48'd0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [24:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [17:0]   coef_data,
  output logic          busy,
  output logic [24:0]   mac_a,
  output logic [17:0]   mac_b,
  output logic [47:0]   mac_c,
  output logic          mac_in_valid,
  input  logic [47:0]   mac_out,
  input  logic          mac_valid,
  output logic [47:0]   y_data,
  output logic          y_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [AW:0]   K_END  = (AW+1)'(NTAPS);
  localparam logic [AW-1:0] R_LAST = AW'(NTAPS - 1);

  state_t        state;
  logic [24:0]   sbuf [NTAPS];
  logic [17:0]   coef [NTAPS];
  logic [AW-1:0] wp;
  logic [AW:0]   k;
  logic [AW-1:0] r;
  logic [47:0]   acc;
  logic [AW-1:0] tap;
  logic [AW-1:0] rd_idx;

  always_comb begin
    tap    = k[AW-1:0];
    rd_idx = wp - tap;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      busy         <= 1'b0;
      mac_a        <= '0;
      mac_b        <= '0;
      mac_c        <= '0;
      mac_in_valid <= 1'b0;
      y_data       <= '0;
      y_valid      <= 1'b0;
      acc          <= '0;
      k            <= '0;
      r            <= '0;
      wp           <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        sbuf[i] <= '0;
        coef[i] <= '0;
      end
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (coef_we)
            coef[coef_addr] <= coef_data;
          // Tap 0 is issued on the handshake edge itself, so the new sample and a
          // same-cycle coefficient write are forwarded rather than read from storage.
          if (in_valid && in_ready) begin
            sbuf[wp]     <= in_data;
            mac_a        <= in_data;
            mac_b        <= (coef_we && coef_addr == '0) ? coef_data : coef[0];
            mac_c        <= ROUND_C;
            mac_in_valid <= 1'b1;
            k            <= (AW+1)'(1);
            r            <= '0;
            acc          <= '0;
            in_ready     <= 1'b0;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (k == K_END) begin
            mac_in_valid <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            mac_c        <= '0;
            wp           <= wp + AW'(1);
            state        <= WAIT;
          end else begin
            mac_a <= sbuf[rd_idx];
            mac_b <= coef[tap];
            mac_c <= '0;
            k     <= k + (AW+1)'(1);
          end
        end
        default: ;
      endcase

      // Results may already return while taps are still being issued.
      if (state != IDLE && mac_valid) begin
        if (r == R_LAST) begin
          y_data   <= acc + mac_out;
          y_valid  <= 1'b1;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end else begin
          acc <= acc + mac_out;
          r   <= r + AW'(1);
        end
      end
    end
  end

endmodule
